// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, bank lifecycle states and the
// bit-reversal index helper used by the FFT, twiddle ROM and output buffer.
package fft_pkg;

    localparam int unsigned FloatPrecision = 64;
    localparam int unsigned LogN           = 8;
    localparam int unsigned N              = 1 << LogN;

    // Widest index bitrev() can reverse; callers cast the result down to logn bits.
    localparam int unsigned MaxLogN = 16;

    typedef enum logic [1:0] {
        Empty,
        Filling,
        Full,
        Draining
    } bank_state_e;

    // Reverses the low w bits of v; bits at and above w are returned as zero.
    function automatic logic [MaxLogN-1:0] bitrev(input logic [MaxLogN-1:0] v,
                                                  input int unsigned       w);
        logic [MaxLogN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxLogN; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_buf_bank.sv
// One frame of complex samples held in flops: a single write port and a
// combinational read port. Contents are deliberately not reset.
module fft_buf_bank #(
    parameter int unsigned Width = 128,
    parameter int unsigned Depth = 256,
    parameter int unsigned AddrW = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_buffer.sv
// Ping-pong capture of streamed FFT output frames with valid/ready replay in
// natural or bit-reversed order. The FFT side never stalls; excess data drops.
module fft_out_buffer
    import fft_pkg::*;
#(
    parameter int unsigned FLOAT_PRECISION = FloatPrecision,
    parameter int unsigned logn            = LogN,
    parameter bit          BITREV          = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [FLOAT_PRECISION-1:0] in_re,
    input  logic [FLOAT_PRECISION-1:0] in_im,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FLOAT_PRECISION-1:0] out_re,
    output logic [FLOAT_PRECISION-1:0] out_im,
    output logic [logn-1:0]            out_idx,
    output logic                       out_last,
    output logic [1:0]                 frame_cnt,
    output logic                       overflow
);

    localparam int unsigned Depth = 1 << logn;
    localparam int unsigned WordW = 2 * FLOAT_PRECISION;

    bank_state_e     bank_q [2];
    bank_state_e     bank_d [2];
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [logn-1:0] wr_cnt_q, wr_cnt_d;
    logic [logn-1:0] rd_cnt_q, rd_cnt_d;
    logic            overflow_q, overflow_d;

    logic            wr_ok, wr_last, rd_fire, rd_last;
    logic [1:0]      wr_en;
    logic [logn-1:0] rd_addr;
    logic [WordW-1:0] bank_rdata [2];
    logic [WordW-1:0] rd_word;
    logic            held0, held1;

    // Write and read can never collide: they require disjoint bank states.
    assign wr_ok    = in_valid && (bank_q[wr_bank_q] inside {Empty, Filling});
    assign wr_last  = wr_ok && (wr_cnt_q == '1);
    assign out_valid = bank_q[rd_bank_q] inside {Full, Draining};
    assign rd_fire  = out_valid && out_ready;
    assign rd_last  = rd_fire && (rd_cnt_q == '1);

    assign wr_en[0] = wr_ok && !wr_bank_q;
    assign wr_en[1] = wr_ok && wr_bank_q;

    if (BITREV) begin : g_bitrev
        assign rd_addr = logn'(bitrev(MaxLogN'(rd_cnt_q), logn));
    end else begin : g_natural
        assign rd_addr = rd_cnt_q;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_buf_bank #(
            .Width (WordW),
            .Depth (Depth),
            .AddrW (logn)
        ) u_bank (
            .clk   (clk),
            .we    (wr_en[b]),
            .waddr (wr_cnt_q),
            .wdata ({in_re, in_im}),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        bank_d     = bank_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        overflow_d = overflow_q;

        if (wr_ok) begin
            wr_cnt_d          = wr_cnt_q + 1'b1;
            bank_d[wr_bank_q] = wr_last ? Full : Filling;
            if (wr_last) begin
                wr_bank_d = !wr_bank_q;
            end
        end else if (in_valid) begin
            overflow_d = 1'b1;
        end

        if (rd_fire) begin
            rd_cnt_d          = rd_cnt_q + 1'b1;
            bank_d[rd_bank_q] = rd_last ? Empty : Draining;
            if (rd_last) begin
                rd_bank_d = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q[0]  <= Empty;
            bank_q[1]  <= Empty;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_word  = bank_rdata[rd_bank_q];
    assign out_re   = out_valid ? rd_word[WordW-1:FLOAT_PRECISION] : '0;
    assign out_im   = out_valid ? rd_word[FLOAT_PRECISION-1:0] : '0;
    assign out_idx  = out_valid ? rd_addr : '0;
    assign out_last = out_valid && (rd_cnt_q == '1);

    assign held0     = bank_q[0] inside {Full, Draining};
    assign held1     = bank_q[1] inside {Full, Draining};
    assign frame_cnt = {1'b0, held0} + {1'b0, held1};
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_out_buffer.sv
// Random and directed frames through natural- and bit-reversed-order buffers,
// compared every cycle against a frame-queue reference model.
module tb_fft_out_buffer;

    localparam int LOGN = 8;
    localparam int NPTS = 256;
    localparam int FP   = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [FP-1:0] in_re, in_im;
    logic          out_ready;

    logic            nv, nl, no, bv, bl, bo;
    logic [FP-1:0]   nre, nim, bre, bim;
    logic [LOGN-1:0] nidx, bidx;
    logic [1:0]      nfc, bfc;

    always #5 clk = ~clk;

    fft_out_buffer #(.FLOAT_PRECISION(FP), .logn(LOGN), .BITREV(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .out_valid(nv), .out_ready(out_ready), .out_re(nre), .out_im(nim), .out_idx(nidx),
        .out_last(nl), .frame_cnt(nfc), .overflow(no)
    );

    fft_out_buffer #(.FLOAT_PRECISION(FP), .logn(LOGN), .BITREV(1'b1)) u_dut_br (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .out_valid(bv), .out_ready(out_ready), .out_re(bre), .out_im(bim), .out_idx(bidx),
        .out_last(bl), .frame_cnt(bfc), .overflow(bo)
    );

    // Reference model: words of completed frames queued in capture order.
    logic [2*FP-1:0] mq [$];
    logic [2*FP-1:0] cur [NPTS];
    int              wcnt, rpos, nf, ba;
    bit              m_ovf, ev, acc, fire, chk_en, rnd_ready;
    logic [2*FP-1:0] w, wb;
    int              n_checks, n_fail;

    task automatic check(input string tag, input logic [2*FP-1:0] got,
                         input logic [2*FP-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int rev_idx(input int k);
        int r = 0;
        for (int i = 0; i < LOGN; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    always @(negedge clk) begin
        nf = mq.size() / NPTS;
        ev = nf > 0;
        if (chk_en) begin
            if (ev) begin
                ba = rev_idx(rpos);
                w  = mq[rpos];
                wb = mq[ba];
            end else begin
                ba = 0;
                w  = '0;
                wb = '0;
            end
            check("valid", nv, ev);
            check("last", nl, ev && rpos == NPTS - 1);
            check("frame_cnt", nfc, nf);
            check("overflow", no, m_ovf);
            check("idx", nidx, ev ? rpos : 0);
            check("re", nre, w[2*FP-1:FP]);
            check("im", nim, w[FP-1:0]);
            check("br_valid", bv, ev);
            check("br_last", bl, ev && rpos == NPTS - 1);
            check("br_idx", bidx, ba);
            check("br_re", bre, wb[2*FP-1:FP]);
            check("br_im", bim, wb[FP-1:0]);
        end
        if (!rst_n) begin
            mq.delete();
            wcnt  = 0;
            rpos  = 0;
            m_ovf = 0;
        end else begin
            acc  = in_valid && nf < 2;
            fire = ev && out_ready;
            if (in_valid && !acc) m_ovf = 1;
            if (acc) begin
                cur[wcnt] = {in_re, in_im};
                wcnt++;
                if (wcnt == NPTS) begin
                    for (int i = 0; i < NPTS; i++) mq.push_back(cur[i]);
                    wcnt = 0;
                end
            end
            if (fire) begin
                rpos++;
                if (rpos == NPTS) begin
                    repeat (NPTS) void'(mq.pop_front());
                    rpos = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int nwords, input bit ramp);
        for (int k = 0; k < nwords; k++) begin
            step();
            in_valid = 1'b1;
            if (ramp) begin
                in_re = $realtobits(real'(k % NPTS));
                in_im = $realtobits(-real'(k % NPTS));
            end else begin
                in_re = {$urandom, $urandom};
                in_im = {$urandom, $urandom};
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (mq.size() != 0 && t < 3000) begin
            step();
            t++;
        end
        check(tag, 1'(mq.size() == 0), 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        out_ready = 1'b0; rnd_ready = 0; chk_en = 0;
        n_checks = 0; n_fail = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        rst_n  = 1'b1;
        step();

        // Single ramp frame, consumer always ready.
        out_ready = 1'b1;
        send(NPTS, 1);
        drain("drain_single");

        // Four contiguous frames.
        send(4 * NPTS, 0);
        drain("drain_b2b");
        check("no_overflow_b2b", no, 1'b0);

        // Random backpressure.
        rnd_ready = 1;
        send(2 * NPTS, 0);
        drain("drain_bp");
        rnd_ready = 0;
        out_ready = 1'b1;
        step();

        // Overflow: consumer stalled across three frames.
        out_ready = 1'b0;
        send(3 * NPTS, 0);
        check("ovf_frame_cnt", nfc, 2'd2);
        check("ovf_flag", no, 1'b1);
        out_ready = 1'b1;
        drain("drain_ovf");

        // Reset with one pending frame plus a partial one.
        out_ready = 1'b0;
        send(NPTS + 100, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_valid", nv, 1'b0);
        check("rst_frame_cnt", nfc, 2'd0);
        check("rst_overflow", no, 1'b0);
        out_ready = 1'b1;
        send(NPTS, 1);
        drain("drain_after_rst");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_out_buffer.md
Name: fft_out_buffer

Overview:
- Downstream consumer of the FFT stage. Captures the streamed complex output frame (fo_re/fo_im qualified by out_valid) into one of two ping-pong banks.
- Replays each completed frame to the next Falcon stage (pointwise mult / ffSampling) over a valid/ready handshake, in natural or bit-reversed order.
- The FFT never stalls: capture is always accepted while a bank is free; overflow is flagged and the excess data is dropped.

Parameters:
- FLOAT_PRECISION, 64, width of each real/imag IEEE-754 word
- logn, 8, log2 of complex points per frame; N = 2^logn (8 -> FALCON512, 9 -> FALCON1024)
- BITREV, 0, 0 = replay in capture order; 1 = replay at bit-reversed capture index

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  connects to FFT out_valid; one complex word per asserted cycle
- in_re  input  FLOAT_PRECISION  connects to FFT fo_re
- in_im  input  FLOAT_PRECISION  connects to FFT fo_im
- out_valid  output  1  replay word available
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- out_re  output  FLOAT_PRECISION  replay real part
- out_im  output  FLOAT_PRECISION  replay imaginary part
- out_idx  output  logn  capture index of the current replay word (after BITREV mapping)
- out_last  output  1  high with the final word (read count N-1) of a frame
- frame_cnt  output  2  number of banks currently FULL or DRAINING (0..2)
- overflow  output  1  sticky; set when in_valid arrives with no bank available for writing

Behaviour:
- Interface: one clock (clk); synchronous active-low reset (rst_n). All state updates on the rising clk edge.
- Reset state: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, both banks EMPTY, overflow=0, out_valid=0, out_last=0, frame_cnt=0. out_re/out_im/out_idx are 0 when out_valid=0.
- Bank storage contents are not cleared by reset.
- Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side, starting a frame:
  - When in_valid=1 and bank[wr_bank] is EMPTY or FILLING, store the word at address wr_cnt.
  - Set bank FILLING and increment wr_cnt.
- Write side, gaps: in_valid may drop mid-frame; wr_cnt holds its value and there is no timeout.
- Write side, frame end:
  - On the write with wr_cnt == N-1, the bank goes FULL, wr_cnt wraps to 0 and wr_bank toggles.
  - This happens in the same cycle as the write.
- Overflow:
  - If in_valid=1 and bank[wr_bank] is FULL or DRAINING, the word is dropped, overflow is set, and wr_cnt is unchanged.
  - overflow clears only on reset.
- Read side, combinational outputs:
  - out_valid = bank[rd_bank] is FULL or DRAINING.
  - Read address = rd_cnt if BITREV=0, else bitrev(rd_cnt).
  - out_re, out_im and out_idx are read combinationally from that address (flop array).
  - out_last = out_valid && rd_cnt == N-1.
- Read side, handshake:
  - On out_valid && out_ready: bank goes DRAINING (if FULL) and rd_cnt increments.
  - On the last word: bank goes EMPTY, rd_cnt wraps to 0 and rd_bank toggles.
  - While out_valid && !out_ready, all out_* outputs hold stable.
- Latency:
  - The first replay word appears the cycle after the capture of word N-1 (out_valid rises on the next edge).
  - Sustained throughput is 1 word/cycle per side.
- Simultaneous events:
  - A frame end on the write side and a frame end on the read side in the same cycle both apply, on different banks.
  - A bank that becomes EMPTY in cycle t is writable in cycle t+1, not in cycle t.
  - Write and read never target the same bank at the same time: write needs EMPTY/FILLING, read needs FULL/DRAINING.
- frame_cnt counts FULL plus DRAINING banks.
- Reset mid-operation: any partial frame and any undrained frames are discarded; state returns to the reset values on the next edge.
- Widths: counters are logn bits and wrap naturally. No arithmetic is performed on the data, which passes through bit-exact.

Decomposition:
- Shared package fft_pkg holds:
  - FLOAT_PRECISION and logn defaults, and N
  - the bank_state enum {EMPTY, FILLING, FULL, DRAINING}
  - a bitrev(logn-bit) function, shared with the FFT and the twiddle ROM index logic
- Sub-module fft_buf_bank: one N x 2*FLOAT_PRECISION flop array with a write port and a combinational read port. It is instantiated twice.
- State machines, counters and handshake logic stay in the top level.

Test Plan:
- Single frame: after reset, feed N=256 words with re = float(k), im = -float(k) and out_ready=1 -> out_valid rises the cycle after k=255. 256 words then replay in order k=0..255, out_last only at k=255, frame_cnt 1->0.
- Back-to-back streaming: 4 frames of contiguous in_valid with out_ready=1 -> every word is replayed bit-exact, overflow stays 0, and frame_cnt never exceeds 2.
- Backpressure: random out_ready (50%), 2 frames -> outputs hold stable while stalled, each frame is replayed completely and in order, with no duplicated or skipped indices.
- Overflow: out_ready=0, 3 frames -> frame_cnt=2 after frame 2. overflow=1 the cycle after frame 3's first word. Frames 1 and 2 then drain intact on out_ready=1, and frame 3's data never appears.
- BITREV=1, logn=8: capture re = float(k) -> first three replays are out_idx 0, 128, 64 with matching data.
- Reset mid-frame: assert rst_n=0 for 1 cycle after 100 words -> out_valid=0 and frame_cnt=0. A fresh frame then replays starting at index 0 with its own data.
